// File: rtl/window_gen_3x3.sv
// window_gen_3x3: 3x3 sliding window generator over a raster pixel stream with two line buffers.
// Optional WINGEN_COORD_EN adds out_x/out_y centre coordinates aligned with out_valid.
module row_ram #(
  parameter int DEPTH = 640,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [AW-1:0] ra,
  input  logic [7:0]    wd,
  output logic [7:0]    q
);
  logic [7:0] mem [0:DEPTH-1];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    q <= mem[ra];
  end
endmodule

module window_gen_3x3 #(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [7:0]           in_pixel,
  output logic                 out_valid,
`ifdef WINGEN_COORD_EN
  output logic [71:0]          out_win,
  output logic [ADDR_BITS-1:0] out_x,
  output logic [ADDR_BITS-1:0] out_y
`else
  output logic [71:0]          out_win
`endif
);
  localparam logic [ADDR_BITS-1:0] XMAX = ADDR_BITS'(WIDTH - 1);
  localparam logic [ADDR_BITS-1:0] YMAX = ADDR_BITS'(HEIGHT - 1);
  localparam logic [ADDR_BITS-1:0] TWO = ADDR_BITS'(2);
  logic [ADDR_BITS-1:0] x, y, cx, cy, x1;
  logic [7:0] pix1, l1_q, l2_q;
  logic v1, g1, v2;
  logic [71:0] sr, sr_nxt;
  assign cx = in_sof ? '0 : x;
  assign cy = in_sof ? '0 : y;
  // new column enters at c=2; rows are {line2, line1, current}
  assign sr_nxt = {pix1, sr[71:56], l1_q, sr[47:32], l2_q, sr[23:8]};
  row_ram #(.DEPTH(WIDTH), .AW(ADDR_BITS)) u_line1 (
    .clk(clk), .we(in_valid), .wa(cx), .ra(cx), .wd(in_pixel), .q(l1_q)
  );
  row_ram #(.DEPTH(WIDTH), .AW(ADDR_BITS)) u_line2 (
    .clk(clk), .we(v1), .wa(x1), .ra(cx), .wd(l1_q), .q(l2_q)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
      x1 <= '0;
      pix1 <= '0;
      v1 <= 1'b0;
      g1 <= 1'b0;
      v2 <= 1'b0;
      sr <= '0;
      out_valid <= 1'b0;
      out_win <= '0;
    end else begin
      if (in_valid) begin
        x <= (cx == XMAX) ? '0 : cx + 1'b1;
        y <= (cx == XMAX) ? ((cy == YMAX) ? '0 : cy + 1'b1) : cy;
      end
      v1 <= in_valid;
      g1 <= in_valid && cx >= TWO && cy >= TWO;
      x1 <= cx;
      pix1 <= in_pixel;
      if (v1) sr <= sr_nxt;
      v2 <= g1;
      out_valid <= v2;
      if (v2) out_win <= sr;
    end
  end
`ifdef WINGEN_COORD_EN
  logic [ADDR_BITS-1:0] cx1, cy1, cx2, cy2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx1 <= '0;
      cy1 <= '0;
      cx2 <= '0;
      cy2 <= '0;
      out_x <= '0;
      out_y <= '0;
    end else begin
      if (in_valid) begin
        cx1 <= cx - 1'b1;
        cy1 <= cy - 1'b1;
      end
      if (v1) begin
        cx2 <= cx1;
        cy2 <= cy1;
      end
      if (v2) begin
        out_x <= cx2;
        out_y <= cy2;
      end
    end
  end
`endif
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: image-array model of the 3x3 window stream, checked every cycle, plus literal window pins.
module tb_window_gen_3x3;
  localparam int W = 4, H = 4, AB = 2;
  localparam logic [71:0] W1 = 72'h22_21_20_12_11_10_02_01_00;
  localparam logic [71:0] W4 = 72'h33_32_31_23_22_21_13_12_11;
  localparam logic [71:0] W1B = 72'h62_61_60_52_51_50_42_41_40;
  logic clk = 0, rst = 1, in_valid = 0, in_sof = 0;
  logic [7:0] in_pixel = 0;
  logic out_valid;
  logic [71:0] out_win;
`ifdef WINGEN_COORD_EN
  logic [AB-1:0] out_x, out_y;
`endif
  window_gen_3x3 #(.WIDTH(W), .HEIGHT(H), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
`ifdef WINGEN_COORD_EN
    .out_x(out_x), .out_y(out_y),
`endif
    .out_valid(out_valid), .out_win(out_win)
  );
  always #5 clk = ~clk;

  int vectors = 0, errors = 0, cyc = 0;
  typedef struct { int due; logic [71:0] win; int cx; int cy; } exp_t;
  exp_t q[$];
  logic [71:0] got[$];
  logic [7:0] img [H][W];
  int mx = 0, my = 0;

  always @(posedge clk) begin
    int px, py;
    exp_t e;
    cyc++;
    if (rst) begin
      mx = 0;
      my = 0;
      q.delete();
    end else if (in_valid) begin
      px = in_sof ? 0 : mx;
      py = in_sof ? 0 : my;
      img[py][px] = in_pixel;
      if (px >= 2 && py >= 2) begin
        e.due = cyc + 2;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            e.win[8*(3*r+c) +: 8] = img[py-2+r][px-2+c];
        e.cx = px - 1;
        e.cy = py - 1;
        q.push_back(e);
      end
      mx = (px == W-1) ? 0 : px + 1;
      my = (px == W-1) ? ((py == H-1) ? 0 : py + 1) : py;
    end
  end

  logic [71:0] prev = 0;
  always @(negedge clk) begin
    logic due;
    exp_t e;
    if (rst) prev = out_win;
    else begin
      due = q.size() > 0 && q[0].due == cyc;
      vectors++;
      if (out_valid !== due) begin
        errors++;
        $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, due);
      end
      if (due) begin
        e = q.pop_front();
        vectors++;
        if (out_win !== e.win) begin
          errors++;
          $display("FAIL out_win cyc=%0d got=%h exp=%h", cyc, out_win, e.win);
        end
`ifdef WINGEN_COORD_EN
        vectors++;
        if (out_x !== AB'(e.cx) || out_y !== AB'(e.cy)) begin
          errors++;
          $display("FAIL coord cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)", cyc, out_x, out_y, e.cx, e.cy);
        end
`endif
        got.push_back(out_win);
      end else if (!out_valid && out_win !== prev) begin
        vectors++;
        errors++;
        $display("FAIL hold cyc=%0d got=%h exp=%h", cyc, out_win, prev);
      end
      prev = out_win;
    end
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pix(input logic [7:0] v, input logic s);
    in_valid = 1;
    in_sof = s;
    in_pixel = v;
    @(posedge clk);
    #2;
    in_valid = 0;
    in_sof = 0;
  endtask

  task automatic frame(input int base, input bit gaps, input bit sof, input int n);
    for (int i = 0; i < n; i++) begin
      pix(8'(base + 16*(i/W) + i%W), sof && i == 0);
      if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
  endtask

  initial begin
    idle(2);
    check("reset_valid", {71'b0, out_valid}, 72'b0);
    check("reset_win", out_win, 72'b0);
    rst = 0;
    idle(2);
    got.delete();
    frame(0, 0, 1, W*H);
    idle(4);
    check("cont_count", 72'(got.size()), 72'd4);
    check("cont_first", got[0], W1);
    check("cont_last", got[3], W4);
    got.delete();
    frame(0, 1, 1, W*H);
    idle(4);
    check("gap_count", 72'(got.size()), 72'd4);
    check("gap_first", got[0], W1);
    check("gap_last", got[3], W4);
    got.delete();
    frame(0, 0, 0, W*H);
    idle(4);
    check("wrap_count", 72'(got.size()), 72'd4);
    got.delete();
    frame(8'h80, 0, 0, 2*W+1);
    frame(0, 0, 1, W*H);
    idle(4);
    check("midsof_count", 72'(got.size()), 72'd4);
    check("midsof_first", got[0], W1);
    frame(0, 0, 1, 3*W+3);
    rst = 1;
    #1;
    check("rst_valid", {71'b0, out_valid}, 72'b0);
    check("rst_win", out_win, 72'b0);
    idle(1);
    rst = 0;
    got.delete();
    frame(0, 0, 0, W*H);
    idle(4);
    check("post_rst_count", 72'(got.size()), 72'd4);
    check("post_rst_first", got[0], W1);
    got.delete();
    frame(8'h40, 0, 1, W*H);
    frame(0, 0, 1, W*H);
    idle(4);
    check("b2b_count", 72'(got.size()), 72'd8);
    check("b2b_f1_first", got[0], W1B);
    check("b2b_f2_first", got[4], W1);
    check("b2b_f2_last", got[7], W4);
    check("drained", 72'(q.size()), 72'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
